// File: rtl/axi_pkg.sv
// Shared AXI write-path types and width constants for the CDC write schedulers.
// The W and AW FIFO entry layouts are defined here so both sides of the bridge agree.
package axi_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;
  localparam int ADDR_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } sched_state_e;

  // W FIFO entry: {wlast, wstrb, wdata}, 37 bits.
  typedef struct packed {
    logic              wlast;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } w_pkt_t;

  // AW FIFO entry body; the master index is prepended by the scheduler.
  typedef struct packed {
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
  } aw_pkt_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after rr_ptr.
// Shared by the write- and read-side schedulers.
module rr_arbiter #(
  parameter int NUM_MST  = 4,
  parameter int MST_BITS = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0]  req,
  input  logic [MST_BITS-1:0] rr_ptr,
  output logic [NUM_MST-1:0]  gnt_onehot,
  output logic [MST_BITS-1:0] gnt_idx,
  output logic                gnt_valid
);

  int idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_MST; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_MST;
      if (!gnt_valid && req[idx]) begin
        gnt_valid       = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = MST_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_w_sched.sv
// Write-side scheduler: round-robin grants one master's AW into the AW CDC FIFO,
// then streams that master's W burst into the W CDC FIFO with a locally generated wlast.
module axi_w_sched
  import axi_pkg::*;
#(
  parameter int NUM_MST  = 4,
  parameter int MST_BITS = $clog2(NUM_MST)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MST-1:0]          m_awvalid,
  output logic [NUM_MST-1:0]          m_awready,
  input  logic [NUM_MST*ID_W-1:0]     m_awid,
  input  logic [NUM_MST*ADDR_W-1:0]   m_awaddr,
  input  logic [NUM_MST*LEN_W-1:0]    m_awlen,
  input  logic [NUM_MST-1:0]          m_wvalid,
  output logic [NUM_MST-1:0]          m_wready,
  input  logic [NUM_MST*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MST*STRB_W-1:0]   m_wstrb,
  input  logic [NUM_MST-1:0]          m_wlast,
  output logic                        aw_push,
  output logic [MST_BITS+40-1:0]      aw_data,
  input  logic                        aw_full,
  output logic                        w_push,
  output logic [36:0]                 w_data,
  input  logic                        w_full,
  output logic                        busy,
  output logic                        wlast_err
);

  // Handshake rule for every channel here: a beat transfers in the cycle where
  // valid and ready are both high; ready never waits on anything registered later.

  sched_state_e        state;
  logic [MST_BITS-1:0] rr_ptr;
  logic [MST_BITS-1:0] grant;
  logic [LEN_W-1:0]    beat_cnt;
  logic                err_q;
  logic                hold;

  logic [NUM_MST-1:0]  arb_onehot;
  logic [MST_BITS-1:0] arb_idx;
  logic                arb_valid;

  logic                run;
  logic                accept;
  logic                w_hs;
  logic                last_beat;
  logic                g_wvalid;
  logic                g_wlast;
  aw_pkt_t             win_aw;
  w_pkt_t              g_w;

  rr_arbiter #(
    .NUM_MST  (NUM_MST),
    .MST_BITS (MST_BITS)
  ) u_arb (
    .req        (m_awvalid),
    .rr_ptr     (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_valid)
  );

  // hold keeps every output quiet for the first cycle after reset is released.
  assign run       = !rst && !hold;
  assign last_beat = (beat_cnt == '0);

  assign win_aw.awid   = m_awid[arb_idx*ID_W +: ID_W];
  assign win_aw.awaddr = m_awaddr[arb_idx*ADDR_W +: ADDR_W];
  assign win_aw.awlen  = m_awlen[arb_idx*LEN_W +: LEN_W];

  assign g_wvalid  = m_wvalid[grant];
  assign g_wlast   = m_wlast[grant];
  assign g_w.wlast = last_beat;
  assign g_w.wstrb = m_wstrb[grant*STRB_W +: STRB_W];
  assign g_w.wdata = m_wdata[grant*DATA_W +: DATA_W];

  assign accept = run && (state == IDLE) && arb_valid && !aw_full;
  assign w_hs   = run && (state == DATA) && g_wvalid && !w_full;

  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    aw_push   = 1'b0;
    aw_data   = '0;
    w_push    = 1'b0;
    w_data    = '0;
    if (accept) begin
      m_awready = arb_onehot;
      aw_push   = 1'b1;
      aw_data   = {arb_idx, win_aw};
    end
    if (run && (state == DATA)) begin
      m_wready[grant] = !w_full;
      w_push          = w_hs;
      w_data          = g_w;
    end
  end

  assign busy      = run && (state == DATA);
  assign wlast_err = err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      hold     <= 1'b1;
    end else begin
      hold <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            grant    <= arb_idx;
            beat_cnt <= win_aw.awlen;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (g_wlast != last_beat) err_q <= 1'b1;
            if (last_beat) begin
              rr_ptr <= MST_BITS'(wrap_inc(int'(grant), NUM_MST));
              state  <= IDLE;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_w_sched.sv
// Randomized bench for axi_w_sched: per-master burst queues drive the DUT, a
// transaction-level round-robin model predicts AW order and the W beat stream.
module tb_axi_w_sched;
  import axi_pkg::*;

  localparam int N  = 4;
  localparam int MB = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N-1:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [N*4-1:0]      m_awid, m_awlen, m_wstrb;
  logic [N*32-1:0]     m_awaddr, m_wdata;
  logic                aw_push, aw_full, w_push, w_full, busy, wlast_err;
  logic [MB+39:0]      aw_data;
  logic [36:0]         w_data;

  axi_w_sched #(.NUM_MST(N), .MST_BITS(MB)) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .aw_push(aw_push), .aw_data(aw_data), .aw_full(aw_full),
    .w_push(w_push), .w_data(w_data), .w_full(w_full),
    .busy(busy), .wlast_err(wlast_err)
  );

  // ---------------- master stimulus state ----------------
  typedef struct packed {
    logic [3:0]        id;
    logic [31:0]       addr;
    logic [3:0]        len;
    logic [15:0][31:0] data;
    logic [15:0][3:0]  strb;
    logic [15:0]       flip;   // beats whose wlast the master gets wrong
  } burst_t;

  burst_t     mq[N][$];
  logic [N-1:0] aw_done;
  logic [N-1:0] wv_hold;
  int         beat_idx[N];

  int  p_wv, p_af, p_wf;
  bit  af_force, wf_force, rst_req;
  int  cyc;

  // ---------------- reference model / scoreboard ----------------
  logic [36:0] exp_q[$];
  bit  m_in_burst;
  int  m_g;
  int  m_ptr;
  bit  m_err;
  bit  prev_rst;
  int  aw_log[$];
  int  aw_cyc[$];
  int  n_wpush, n_busy;
  int  n_checks, n_pass;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int log_at(input int i);
    return (aw_log.size() > i) ? aw_log[i] : -1;
  endfunction

  task automatic add_burst(input int m, input int len, input logic [15:0] flip);
    burst_t b;
    b.id   = 4'($urandom_range(0, 15));
    b.addr = $urandom;
    b.len  = 4'(len);
    for (int i = 0; i < 16; i++) begin
      b.data[i] = $urandom;
      b.strb[i] = 4'($urandom_range(0, 15));
    end
    b.flip = flip;
    mq[m].push_back(b);
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    burst_t b;
    rst       = rst_req;
    aw_full   = af_force || ($urandom_range(0, 99) < p_af);
    w_full    = wf_force || ($urandom_range(0, 99) < p_wf);
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_wdata = '0; m_wstrb = '0;
    for (int m = 0; m < N; m++) begin
      if (mq[m].size() != 0) begin
        b = mq[m][0];
        m_awvalid[m]        = !aw_done[m];
        m_awid[m*4 +: 4]    = b.id;
        m_awaddr[m*32 +: 32] = b.addr;
        m_awlen[m*4 +: 4]   = b.len;
        wv_hold[m]          = wv_hold[m] || ($urandom_range(0, 99) < p_wv);
        m_wvalid[m]         = wv_hold[m];
        m_wdata[m*32 +: 32] = b.data[beat_idx[m]];
        m_wstrb[m*4 +: 4]   = b.strb[beat_idx[m]];
        m_wlast[m]          = (beat_idx[m] == int'(b.len)) ^ b.flip[beat_idx[m]];
      end
    end
  endtask

  // ---------------- per-cycle model check ----------------
  task automatic check_cycle();
    burst_t b;
    int winner;
    logic [36:0] exp_w;
    bit hs;
    if (aw_push === 1'b1) begin
      aw_log.push_back(int'(aw_data[MB+39:40]));
      aw_cyc.push_back(cyc);
    end
    if (w_push === 1'b1) n_wpush++;
    if (busy === 1'b1) n_busy++;

    check("wlast_err", wlast_err, rst ? 1'b0 : m_err);

    if (rst || prev_rst) begin
      check("quiet_after_rst", {m_awready, m_wready, aw_push, w_push, busy}, '0);
      if (rst) begin
        for (int m = 0; m < N; m++) begin
          if (aw_done[m]) void'(mq[m].pop_front());
          aw_done[m]  = 1'b0;
          wv_hold[m]  = 1'b0;
          beat_idx[m] = 0;
        end
        exp_q.delete();
        m_in_burst = 1'b0;
        m_ptr      = 0;
        m_err      = 1'b0;
      end
    end else if (!m_in_burst) begin
      winner = -1;
      if (!aw_full)
        for (int k = 0; k < N; k++)
          if (winner < 0 && m_awvalid[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
      check("busy_idle", busy, 1'b0);
      check("wpush_idle", {m_wready, w_push}, '0);
      if (winner >= 0) begin
        b = mq[winner][0];
        check("aw_push", aw_push, 1'b1);
        check("awready", m_awready, 64'(1) << winner);
        check("aw_data", aw_data, {MB'(winner), b.id, b.addr, b.len});
        m_in_burst      = 1'b1;
        m_g             = winner;
        aw_done[winner] = 1'b1;
        for (int i = 0; i <= int'(b.len); i++)
          exp_q.push_back({i == int'(b.len), b.strb[i], b.data[i]});
      end else begin
        check("aw_hold", {m_awready, aw_push}, '0);
      end
    end else begin
      b  = mq[m_g][0];
      hs = m_wvalid[m_g] && !w_full;
      check("busy_data", busy, 1'b1);
      check("aw_quiet", {m_awready, aw_push}, '0);
      check("wready", m_wready, w_full ? 64'(0) : (64'(1) << m_g));
      check("w_push", w_push, hs);
      if (hs) begin
        if (exp_q.size() == 0) check("exp_q_level", 0, 1);
        else begin
          exp_w = exp_q.pop_front();
          check("w_data", w_data, exp_w);
        end
        if (b.flip[beat_idx[m_g]]) m_err = 1'b1;
        wv_hold[m_g] = 1'b0;
        if (beat_idx[m_g] == int'(b.len)) begin
          void'(mq[m_g].pop_front());
          aw_done[m_g]  = 1'b0;
          beat_idx[m_g] = 0;
          m_in_burst    = 1'b0;
          m_ptr         = (m_g + 1) % N;
        end else begin
          beat_idx[m_g]++;
        end
      end
    end
    prev_rst = rst;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  function automatic int pending();
    int s = 0;
    for (int m = 0; m < N; m++) s += mq[m].size();
    return s;
  endfunction

  task automatic run_until_idle(input int max_cycles);
    int c = 0;
    while ((pending() != 0 || m_in_burst) && c < max_cycles) begin
      cycle();
      c++;
    end
    check("drain_timeout", pending(), 0);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int ab, wb, bb, c0;
  int t2_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; aw_full = 1'b0; w_full = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_wdata = '0; m_wstrb = '0;
    aw_done = '0; wv_hold = '0;
    for (int m = 0; m < N; m++) beat_idx[m] = 0;
    p_wv = 100; p_af = 0; p_wf = 0;
    af_force = 1'b0; wf_force = 1'b0; rst_req = 1'b1;
    prev_rst = 1'b1; m_in_burst = 1'b0; m_ptr = 0; m_err = 1'b0; m_g = 0;
    cyc = 0; n_wpush = 0; n_busy = 0; n_checks = 0; n_pass = 0;

    // single 4-beat burst from M1
    do_reset();
    c0 = cyc; ab = aw_log.size(); wb = n_wpush; bb = n_busy;
    add_burst(1, 3, 16'h0);
    run_until_idle(100);
    check("t1_aw_mst", log_at(ab), 1);
    check("t1_aw_cycle", (aw_cyc.size() > ab) ? aw_cyc[ab] - c0 : -1, 2);
    check("t1_wpush", n_wpush - wb, 4);
    check("t1_busy", n_busy - bb, 4);
    // pointer now sits at M2
    ab = aw_log.size();
    add_burst(0, 0, 16'h0);
    add_burst(2, 0, 16'h0);
    run_until_idle(100);
    check("t1_ptr_first", log_at(ab), 2);
    check("t1_ptr_second", log_at(ab + 1), 0);

    // all four request together, M0 has a second burst queued
    do_reset();
    ab = aw_log.size();
    for (int m = 0; m < N; m++) add_burst(m, 0, 16'h0);
    add_burst(0, 0, 16'h0);
    run_until_idle(200);
    for (int i = 0; i < 5; i++) check("t2_order", log_at(ab + i), t2_exp[i]);
    for (int i = 0; i < 3; i++)
      check("t2_spacing", (aw_cyc.size() > ab + i + 1) ? aw_cyc[ab+i+1] - aw_cyc[ab+i] : -1, 2);

    // W FIFO full for 3 cycles in the middle of a 4-beat burst
    wb = n_wpush;
    add_burst(2, 3, 16'h0);
    for (int k = 0; k < 50 && beat_idx[2] != 2; k++) cycle();
    wf_force = 1'b1;
    bb = n_wpush;
    for (int k = 0; k < 3; k++) cycle();
    check("t3_stall_pushes", n_wpush - bb, 0);
    wf_force = 1'b0;
    run_until_idle(100);
    check("t3_total_pushes", n_wpush - wb, 4);

    // AW FIFO full holds off M2
    ab = aw_log.size();
    af_force = 1'b1;
    add_burst(2, 0, 16'h0);
    for (int k = 0; k < 3; k++) cycle();
    check("t4_no_push", aw_log.size() - ab, 0);
    af_force = 1'b0;
    cycle();
    check("t4_push_now", log_at(ab), 2);
    run_until_idle(100);

    // M0 asserts wlast one beat early
    wb = n_wpush;
    add_burst(0, 1, 16'h0001);
    run_until_idle(100);
    check("t5_err_set", wlast_err, 1'b1);
    check("t5_pushes", n_wpush - wb, 2);
    for (int k = 0; k < 3; k++) cycle();
    check("t5_err_sticky", wlast_err, 1'b1);

    // reset in the middle of a burst
    add_burst(3, 3, 16'h0);
    for (int k = 0; k < 50 && beat_idx[3] != 2; k++) cycle();
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    check("t6_err_clear", wlast_err, 1'b0);
    check("t6_quiet", {m_wready, w_push, busy}, '0);
    ab = aw_log.size();
    add_burst(2, 0, 16'h0);
    add_burst(0, 0, 16'h0);
    run_until_idle(100);
    check("t6_ptr_zero", log_at(ab), 0);

    // randomized traffic with back-pressure, bad wlast and occasional reset
    p_wv = 60; p_af = 20; p_wf = 25;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        int m = $urandom_range(0, N - 1);
        int len = $urandom_range(0, 15);
        if (mq[m].size() < 3)
          add_burst(m, len, ($urandom_range(0, 9) == 0) ? (16'h1 << $urandom_range(0, len)) : 16'h0);
      end
      rst_req = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst_req = 1'b0;
    run_until_idle(5000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
